yasac_port_uart_tx: RTL and testbench
=====================================

YASAC_PORT_UART_TX -- requirements
Module: yasac_port_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, giving clock cycles per serial bit (115200 baud at 50 MHz); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the number of byte entries; power of two, 2..16.
REQ-003 SHALL have port CLK  input  1  clock, rising edge; the design has one clock.
REQ-004 SHALL have port RESET  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port PORT_DATA  input  8  byte written by the processor to its output port.
REQ-006 SHALL have port PORT_WE  input  1  one-cycle write strobe qualifying PORT_DATA.
REQ-007 SHALL have port TXD  output  1  serial line, idle high.
REQ-008 SHALL have port BUSY  output  1  high while a frame is being shifted out.
REQ-009 SHALL have port FULL  output  1  FIFO holds FIFO_DEPTH entries.
REQ-010 SHALL have port EMPTY  output  1  FIFO holds 0 entries.
REQ-011 SHALL have port COUNT  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-012 SHALL have port OVERRUN  output  1  sticky flag: a write was dropped.

Function
REQ-013 SHALL sample PORT_DATA into the FIFO tail on each rising CLK edge where PORT_WE=1 and the FIFO is not full.
REQ-014 SHALL drop a write arriving while the FIFO is full and no pop occurs that edge, leave the FIFO unchanged, and set OVERRUN=1 from the next cycle until reset.
REQ-015 SHALL accept a write that arrives on the same edge as a pop, even when the FIFO is full, leaving COUNT unchanged.
REQ-016 SHALL derive FULL, EMPTY and COUNT from registered pointers and an occupancy counter; pointers wrap modulo FIFO_DEPTH.
REQ-017 SHALL implement the transmitter FSM states IDLE, START, DATA, STOP.
REQ-018 IDLE: TXD=1 and BUSY=0; on an edge with the FIFO non-empty, SHALL pop the head byte into the shift register and enter START.
REQ-019 START: TXD=0 for CLKS_PER_BIT cycles, then SHALL enter DATA.
REQ-020 DATA: SHALL send 8 bits LSB first, each for CLKS_PER_BIT cycles, using a 3-bit bit index, then enter STOP.
REQ-021 STOP: TXD=1 for CLKS_PER_BIT cycles; at the end SHALL pop and enter START directly if the FIFO is non-empty (no idle gap), otherwise enter IDLE.
REQ-022 A frame SHALL last exactly 10*CLKS_PER_BIT cycles; BUSY SHALL be 1 in START, DATA and STOP.
REQ-023 Latency: a byte written at edge k into an empty FIFO with the FSM in IDLE SHALL be in the FIFO after edge k (EMPTY=0), popped at edge k+1, and drive TXD=0 from edge k+1.
REQ-024 An empty-FIFO write at edge k SHALL therefore show EMPTY=0 for exactly one cycle (between edges k and k+1).
REQ-025 The baud counter SHALL count 0..CLKS_PER_BIT-1 and reload at each bit boundary; it SHALL hold at 0 in IDLE.
REQ-026 TXD SHALL be driven from a register (glitch-free).

Reset
REQ-027 SHALL, on any CLK edge with RESET=0, set the FSM to IDLE, TXD=1, BUSY=0, clear the pointers, counters and shift register, set COUNT=0, EMPTY=1, FULL=0 and OVERRUN=0.
REQ-028 SHALL treat reset asserted mid-frame as an abort: TXD=1 from that edge, all queued bytes discarded, no partial-frame completion.
REQ-029 SHALL ignore PORT_WE on any edge where RESET=0.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-030 Single byte: write 0xA5 into an idle block -> TXD sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles, starting one edge after the write; BUSY high for 40 cycles; then IDLE with EMPTY=1.
REQ-031 Back-to-back: write 0x00, 0xFF, 0x3C on consecutive cycles -> three contiguous 40-cycle frames with no idle gap; COUNT peaks at 2; EMPTY=1 after the third pop.
REQ-032 Overrun: with a frame in progress, write 5 bytes -> FULL=1 after the 4th write; the 5th write is dropped and OVERRUN=1; only the 4 queued bytes plus the in-flight byte are transmitted.
REQ-033 Simultaneous: with FULL=1, write a byte on the STOP-end pop edge -> write accepted, COUNT stays 4, OVERRUN stays 0.
REQ-034 Reset mid-frame: assert RESET=0 for one edge during DATA with 2 bytes queued -> TXD=1, COUNT=0, BUSY=0 after that edge; no further frames.
REQ-035 Pointer wrap: stream 9 bytes 0x01..0x09, each written after the previous pop -> all 9 are transmitted in order, with no loss or duplication across the pointer wrap.

Source files
------------

// File: rtl/yasac_port_uart_tx.sv
// rtl/yasac_port_uart_tx.sv - byte FIFO feeding an 8N1 serial transmitter
module yasac_port_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [7:0]                    PORT_DATA,
  input  logic                          PORT_WE,
  output logic                          TXD,
  output logic                          BUSY,
  output logic                          FULL,
  output logic                          EMPTY,
  output logic [$clog2(FIFO_DEPTH):0]   COUNT,
  output logic                          OVERRUN
);

  localparam int               AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state;
  logic [15:0]     r_baud;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_txd;
  logic            r_busy;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            r_overrun;

  logic w_bit_end;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_bit_end = (r_baud == BAUD_LAST);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == DEPTH_C);
  // A pop frees a slot on the same edge, so a write to a full FIFO still lands.
  assign w_pop     = RESET && !w_empty &&
                     ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
  assign w_push    = RESET && PORT_WE && (!w_full || w_pop);
  assign w_drop    = RESET && PORT_WE && w_full && !w_pop;

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= PORT_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overrun <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_state <= S_START;
            r_txd   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_state   <= S_DATA;
            r_txd     <= r_shift[0];
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
              r_txd   <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_txd     <= r_shift[r_bit_idx + 3'd1];
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift <= r_mem[r_rd_ptr];
              r_state <= S_START;
              r_txd   <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_txd   <= 1'b1;
              r_busy  <= 1'b0;
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign TXD     = r_txd;
  assign BUSY    = r_busy;
  assign FULL    = w_full;
  assign EMPTY   = w_empty;
  assign COUNT   = r_count;
  assign OVERRUN = r_overrun;

endmodule

// File: tb/tb_yasac_port_uart_tx.sv
// tb/tb_yasac_port_uart_tx.sv - checks the UART TX against a frame-timeline model
module tb_yasac_port_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       RESET;
  logic [7:0] PORT_DATA;
  logic       PORT_WE;
  logic       TXD;
  logic       BUSY;
  logic       FULL;
  logic       EMPTY;
  logic [2:0] COUNT;
  logic       OVERRUN;

  yasac_port_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(clk), .RESET(RESET), .PORT_DATA(PORT_DATA), .PORT_WE(PORT_WE),
    .TXD(TXD), .BUSY(BUSY), .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT), .OVERRUN(OVERRUN)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: queued bytes plus the position inside the current 10-bit frame.
  logic [7:0] m_q[$];
  logic [7:0] m_cur;
  bit         m_active;
  int         m_pos;
  bit         m_ovr;
  bit         m_valid;
  bit         m_rst;
  bit         m_pop;
  int         cyc;

  logic [7:0] rx_q[$];
  logic [7:0] rx_byte;
  bit         rx_on;
  int         rx_pos;

  int         exp_q[$];
  int         a5_seq[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  int         base, peak, bcnt, falls, k0;
  logic       prev_busy;
  logic [7:0] seq3[3] = '{8'h00, 8'hFF, 8'h3C};

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic int exp_txd();
    int seg;
    if (!m_active) return 1;
    seg = m_pos / CPB;
    if (seg == 0) return 0;
    if (seg == 9) return 1;
    return int'(m_cur[seg-1]);
  endfunction

  task automatic put(input logic [7:0] d);
    PORT_WE   = 1'b1;
    PORT_DATA = d;
    @(negedge clk);
    PORT_WE   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    @(negedge clk);
    RESET = 1'b1;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (!BUSY && EMPTY) done = 1;
    end
    check("wait_idle_timeout", int'(done), 1);
  endtask

  task automatic expect_rx(input int b);
    check("rx_len", rx_q.size() - b, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (b + i < rx_q.size()) check("rx_byte", int'(rx_q[b+i]), exp_q[i]);
    end
  endtask

  initial begin
    clk       = 1'b0;
    RESET     = 1'b0;
    PORT_WE   = 1'b0;
    PORT_DATA = 8'h00;
    cyc       = 0;

    fork
      forever begin
        @(posedge clk);
        cyc++;
        if (!RESET) begin
          m_q.delete();
          m_active = 0;
          m_pos    = 0;
          m_ovr    = 0;
          m_valid  = 1;
          m_rst    = 1;
        end else begin
          m_rst = 0;
          m_pop = 0;
          if (m_q.size() > 0 && (!m_active || m_pos == FRAME - 1)) begin
            m_pop = 1;
            m_cur = m_q.pop_front();
          end
          if (PORT_WE) begin
            if (m_q.size() < DEPTH) m_q.push_back(PORT_DATA);
            else m_ovr = 1;
          end
          if (m_pop) begin
            m_active = 1;
            m_pos    = 0;
          end else if (m_active) begin
            if (m_pos == FRAME - 1) m_active = 0;
            else m_pos++;
          end
        end
      end
      forever begin
        @(negedge clk);
        if (m_valid) begin
          check("txd", int'(TXD), exp_txd());
          check("busy", int'(BUSY), int'(m_active));
          check("count", int'(COUNT), m_q.size());
          check("empty", int'(EMPTY), int'(m_q.size() == 0));
          check("full", int'(FULL), int'(m_q.size() == DEPTH));
          check("overrun", int'(OVERRUN), int'(m_ovr));
        end
      end
      forever begin
        @(negedge clk);
        if (m_rst) begin
          rx_on = 0;
        end else if (!rx_on) begin
          if (m_valid && TXD == 1'b0) begin
            rx_on   = 1;
            rx_pos  = 0;
            rx_byte = 8'h00;
          end
        end else begin
          rx_pos++;
          if (rx_pos % CPB == CPB / 2 && rx_pos / CPB >= 1 && rx_pos / CPB <= 8)
            rx_byte[rx_pos/CPB-1] = TXD;
          if (rx_pos == 9 * CPB + CPB / 2) begin
            check("rx_stop_bit", int'(TXD), 1);
            rx_q.push_back(rx_byte);
            rx_on = 0;
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    RESET = 1'b1;
    check("rst_txd", int'(TXD), 1);
    check("rst_busy", int'(BUSY), 0);
    check("rst_empty", int'(EMPTY), 1);
    check("rst_full", int'(FULL), 0);
    check("rst_count", int'(COUNT), 0);
    check("rst_overrun", int'(OVERRUN), 0);

    // Single byte 0xA5
    base = rx_q.size();
    put(8'hA5);
    check("a5_empty_after_write", int'(EMPTY), 0);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      check("a5_txd_seq", int'(TXD), a5_seq[i/CPB]);
      check("a5_busy", int'(BUSY), 1);
    end
    @(negedge clk);
    check("a5_busy_end", int'(BUSY), 0);
    check("a5_empty_end", int'(EMPTY), 1);
    exp_q = '{8'hA5};
    expect_rx(base);

    // Back-to-back writes
    idle(3);
    base = rx_q.size(); peak = 0; bcnt = 0; falls = 0; prev_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      PORT_WE   = 1'b1;
      PORT_DATA = seq3[i];
      @(negedge clk);
      if (int'(COUNT) > peak) peak = int'(COUNT);
      bcnt += int'(BUSY);
      prev_busy = BUSY;
    end
    PORT_WE = 1'b0;
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      if (int'(COUNT) > peak) peak = int'(COUNT);
      bcnt += int'(BUSY);
      if (prev_busy && !BUSY) falls++;
      prev_busy = BUSY;
    end
    check("b2b_peak_count", peak, 2);
    check("b2b_busy_cycles", bcnt, 3 * FRAME);
    check("b2b_busy_falls", falls, 1);
    check("b2b_empty_end", int'(EMPTY), 1);
    exp_q = '{8'h00, 8'hFF, 8'h3C};
    expect_rx(base);

    // Overrun
    base = rx_q.size();
    put(8'h11);
    idle(3);
    put(8'h21); put(8'h22); put(8'h23); put(8'h24);
    check("ovr_full_after_4", int'(FULL), 1);
    check("ovr_count_after_4", int'(COUNT), 4);
    check("ovr_flag_before", int'(OVERRUN), 0);
    put(8'h25);
    check("ovr_flag_after", int'(OVERRUN), 1);
    check("ovr_count_after_5", int'(COUNT), 4);
    wait_idle();
    check("ovr_sticky", int'(OVERRUN), 1);
    exp_q = '{8'h11, 8'h21, 8'h22, 8'h23, 8'h24};
    expect_rx(base);

    // Write on the STOP-end pop edge while full
    do_reset();
    check("sim_overrun_cleared", int'(OVERRUN), 0);
    base = rx_q.size();
    put(8'h5A);
    k0 = cyc;
    put(8'h61); put(8'h62); put(8'h63); put(8'h64);
    check("sim_full", int'(FULL), 1);
    while (cyc < k0 + FRAME) @(negedge clk);
    put(8'h65);
    check("sim_count", int'(COUNT), 4);
    check("sim_full_after", int'(FULL), 1);
    check("sim_overrun", int'(OVERRUN), 0);
    wait_idle();
    exp_q = '{8'h5A, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
    expect_rx(base);

    // Reset mid-frame, with a write strobe that must be ignored
    base = rx_q.size();
    put(8'h81); put(8'h82); put(8'h83);
    idle(10);
    check("abort_count_before", int'(COUNT), 2);
    check("abort_busy_before", int'(BUSY), 1);
    RESET     = 1'b0;
    PORT_WE   = 1'b1;
    PORT_DATA = 8'h99;
    @(negedge clk);
    RESET   = 1'b1;
    PORT_WE = 1'b0;
    check("abort_txd", int'(TXD), 1);
    check("abort_count", int'(COUNT), 0);
    check("abort_busy", int'(BUSY), 0);
    check("abort_empty", int'(EMPTY), 1);
    bcnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      bcnt += int'(BUSY);
    end
    check("abort_no_frames", bcnt, 0);
    check("abort_rx_none", rx_q.size() - base, 0);

    // Pointer wrap over nine bytes
    base = rx_q.size();
    for (int v = 1; v <= 9; v++) begin
      put(8'(v));
      idle(FRAME - 1);
    end
    wait_idle();
    check("wrap_overrun", int'(OVERRUN), 0);
    exp_q = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    expect_rx(base);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
